cntr_run_scheduler: RTL and testbench

// - Shares one 0..TERMINAL wrapping counter datapath and its control FSM between NREQ requesters.
// - Each requester asks for a counting run of a given length.
// - Block arbitrates round-robin, clears the counter, drives its enable until the run length is reached,

---
 rtl/cntr_run_scheduler_if.sv | 27 ++
 rtl/cntr_run_scheduler.sv | 166 ++++++++++++++++
 tb/tb_cntr_run_scheduler.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cntr_run_scheduler_if.sv
// Request/grant and counter-control bundle for cntr_run_scheduler.
// master: requester side plus the counter datapath (drives req, run_len and cnt_val).
// slave:  the scheduler (drives grant, completion and counter-control outputs).
interface cntr_run_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 32
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] run_len;
  logic [CNT_W-1:0]      cnt_val;
  logic                  cnt_en;
  logic                  cnt_clr;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [NREQ-1:0]       abort;
  logic                  busy;

  modport master (
    output req, run_len, cnt_val,
    input  cnt_en, cnt_clr, gnt, done, abort, busy
  );

  modport slave (
    input  req, run_len, cnt_val,
    output cnt_en, cnt_clr, gnt, done, abort, busy
  );
endinterface

// File: rtl/cntr_run_scheduler.sv
// Round-robin scheduler that lends one shared 0..TERMINAL counter to NREQ requesters.
// A winner gets the counter cleared, enabled until its latched run length is
// reached, and then a one-cycle done pulse. Dropping req mid-run aborts the run.
// Optional build macro: CNTR_SCHED_TIMEOUT_EN adds a RUN-state watchdog that
// aborts a run whose counter fails to reach the target within len+4 cycles.
module cntr_run_scheduler #(
  parameter int NREQ     = 4,
  parameter int CNT_W    = 32,
  parameter int TERMINAL = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  cntr_run_scheduler_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TERMINAL);
  localparam logic [IW-1:0]    RR_INIT = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [IW-1:0]     rr_reg, rr_next;
  logic [CNT_W-1:0]  len_reg, len_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [NREQ-1:0]   done_reg, done_next;
  logic [NREQ-1:0]   abort_reg, abort_next;
  logic              clr_reg, clr_next;
`ifdef CNTR_SCHED_TIMEOUT_EN
  logic [CNT_W:0]    wd_reg, wd_next;
`endif

  // Per-requester run length, saturated so a run can never wrap the counter.
  logic [CNT_W-1:0] sat_len [NREQ];
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sat
      assign sat_len[gi] = (bus.run_len[gi*CNT_W +: CNT_W] > TERM)
                           ? TERM : bus.run_len[gi*CNT_W +: CNT_W];
    end
  endgenerate

  // Round-robin pick: first set req bit searching upward from rr+1 with wrap.
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  int            cand;
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_reg) + k) % NREQ;
      if (!pick_valid && bus.req[cand[IW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      rr_reg    <= RR_INIT;
      len_reg   <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
      abort_reg <= '0;
      clr_reg   <= 1'b0;
`ifdef CNTR_SCHED_TIMEOUT_EN
      wd_reg    <= '0;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      rr_reg    <= rr_next;
      len_reg   <= len_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      abort_reg <= abort_next;
      clr_reg   <= clr_next;
`ifdef CNTR_SCHED_TIMEOUT_EN
      wd_reg    <= wd_next;
`endif
    end
  end

  // Next-state logic; pulse outputs default low, grant and latches hold.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    rr_next    = rr_reg;
    len_next   = len_reg;
    gnt_next   = gnt_reg;
    done_next  = '0;
    abort_next = '0;
    clr_next   = 1'b0;
`ifdef CNTR_SCHED_TIMEOUT_EN
    wd_next    = wd_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          idx_next   = pick_idx;
          len_next   = sat_len[pick_idx];
          gnt_next   = NREQ'(1) << pick_idx;
          clr_next   = 1'b1;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        if (!bus.req[idx_reg]) begin
          abort_next = NREQ'(1) << idx_reg;
          gnt_next   = '0;
          rr_next    = idx_reg;
          state_next = IDLE;
        end else begin
          // Zero-length runs also pass through one RUN cycle with the enable
          // held off, so done timing is uniform (cycle len+3) for every length.
          state_next = RUN;
`ifdef CNTR_SCHED_TIMEOUT_EN
          wd_next    = '0;
`endif
        end
      end
      RUN: begin
        if (!bus.req[idx_reg]) begin
          abort_next = NREQ'(1) << idx_reg;
          gnt_next   = '0;
          rr_next    = idx_reg;
          state_next = IDLE;
        end else if ((bus.cnt_val == len_reg) || (len_reg == '0)) begin
          done_next  = NREQ'(1) << idx_reg;
          state_next = DONE;
        end
`ifdef CNTR_SCHED_TIMEOUT_EN
        else if ((wd_reg + (CNT_W+1)'(1)) == ({1'b0, len_reg} + (CNT_W+1)'(4))) begin
          // Counter looks stuck: give the slot back rather than hang.
          abort_next = NREQ'(1) << idx_reg;
          gnt_next   = '0;
          rr_next    = idx_reg;
          state_next = IDLE;
        end else begin
          wd_next = wd_reg + (CNT_W+1)'(1);
        end
`endif
      end
      DONE: begin
        gnt_next   = '0;
        rr_next    = idx_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter enable follows the live counter value so it drops in the target cycle.
  assign bus.cnt_en  = (state_reg == RUN) && (len_reg != '0) && (bus.cnt_val != len_reg);
  assign bus.cnt_clr = clr_reg;
  assign bus.gnt     = gnt_reg;
  assign bus.done    = done_reg;
  assign bus.abort   = abort_reg;
  assign bus.busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_cntr_run_scheduler.sv
// Directed bench for cntr_run_scheduler: vector table of single runs plus
// rotation, abort and reset-mid-run sequences against a modelled counter.
module tb_cntr_run_scheduler;
  localparam int NREQ     = 4;
  localparam int CNT_W    = 32;
  localparam int TERMINAL = 127;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] cnt_q = '0;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               viol = 0;
  int               cyc = 0;

  cntr_run_scheduler_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus_if ();

  cntr_run_scheduler #(.NREQ(NREQ), .CNT_W(CNT_W), .TERMINAL(TERMINAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Shared wrapping counter datapath driven by the scheduler.
  always @(posedge clk) begin
    if (bus_if.cnt_clr)     cnt_q <= '0;
    else if (bus_if.cnt_en) cnt_q <= (cnt_q == CNT_W'(TERMINAL)) ? '0 : cnt_q + 1;
  end
  assign bus_if.cnt_val = cnt_q;

  // Invariant monitor: exclusive one-hot outputs, never clear and enable together.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.cnt_en && bus_if.cnt_clr) viol++;
      if ($countones(bus_if.gnt | bus_if.done | bus_if.abort) > 1) viol++;
    end
  end

  typedef struct {
    logic [NREQ-1:0]            req;
    logic [NREQ-1:0][CNT_W-1:0] len;
    int                         exp_idx;
    int                         exp_en;
    int                         exp_done;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_cnt(input logic [CNT_W-1:0] val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cnt_q == val) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(input int budget, output logic [NREQ-1:0] dv);
    dv = '0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus_if.done != '0) begin
        dv = bus_if.done;
        break;
      end
    end
  endtask

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    logic [NREQ-1:0]       exp_gnt;
    logic [NREQ-1:0]       first_gnt, done_val, dv;
    logic                  clr_at;
    int                    en_cnt, done_cyc, hold_bad, ng;
    logic [CNT_W-1:0]      max_cnt;
    int                    order [5];
    int                    at [5];
    int                    dcnt [NREQ];
    logic [NREQ-1:0]       g, prev;
    bit                    ok;

    // lens listed as {len3, len2, len1, len0}
    vec[0] = '{4'b0001, {32'd0,   32'd0,   32'd0, 32'd5},   0, 5,   8};
    vec[1] = '{4'b0010, {32'd0,   32'd0,   32'd0, 32'd0},   1, 0,   3};
    vec[2] = '{4'b0100, {32'd0,   32'd300, 32'd0, 32'd0},   2, 127, 130};
    vec[3] = '{4'b1111, {32'd3,   32'd3,   32'd3, 32'd3},   3, 3,   6};
    vec[4] = '{4'b1111, {32'd1,   32'd6,   32'd4, 32'd2},   0, 2,   5};
    vec[5] = '{4'b1010, {32'd1,   32'd6,   32'd4, 32'd2},   1, 4,   7};
    vec[6] = '{4'b1001, {32'd1,   32'd6,   32'd4, 32'd2},   3, 1,   4};
    vec[7] = '{4'b0110, {32'd1,   32'd6,   32'd4, 32'd2},   1, 4,   7};
    vec[8] = '{4'b0001, {32'd0,   32'd0,   32'd0, 32'd127}, 0, 127, 130};
    vec[9] = '{4'b0001, {32'd0,   32'd0,   32'd0, 32'd128}, 0, 127, 130};

    bus_if.req     = '0;
    bus_if.run_len = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_gnt",   64'(bus_if.gnt),     64'd0);
    check("rst_done",  64'(bus_if.done),    64'd0);
    check("rst_abort", 64'(bus_if.abort),   64'd0);
    check("rst_busy",  64'(bus_if.busy),    64'd0);
    check("rst_en",    64'(bus_if.cnt_en),  64'd0);
    check("rst_clr",   64'(bus_if.cnt_clr), 64'd0);
    rst = 1'b0;

    // Table of single runs; rr pointer carries from one vector to the next.
    for (int v = 0; v < NV; v++) begin
      bus_if.req     = vec[v].req;
      bus_if.run_len = vec[v].len;
      exp_gnt   = NREQ'(1) << vec[v].exp_idx;
      first_gnt = '0;
      clr_at    = 1'b0;
      en_cnt    = 0;
      done_cyc  = 0;
      done_val  = '0;
      hold_bad  = 0;
      max_cnt   = '0;
      for (int c = 1; c <= 400 && done_cyc == 0; c++) begin
        tick();
        if (c == 1) begin
          first_gnt = bus_if.gnt;
          clr_at    = bus_if.cnt_clr;
        end
        if (bus_if.cnt_en) en_cnt++;
        if (c >= 2 && cnt_q > max_cnt) max_cnt = cnt_q;
        if (bus_if.gnt !== exp_gnt) hold_bad++;
        if (bus_if.done != '0) begin
          done_cyc = c;
          done_val = bus_if.done;
        end
      end
      bus_if.req = '0;
      $display("txn vec%0d: req=%b gnt=%b en=%0d done=%b at cycle %0d peak=%0d",
               v, vec[v].req, first_gnt, en_cnt, done_val, done_cyc, max_cnt);
      check("vec_gnt",      64'(first_gnt), 64'(exp_gnt));
      check("vec_clr",      64'(clr_at),    64'd1);
      check("vec_en_count", 64'(en_cnt),    64'(vec[v].exp_en));
      check("vec_done_cyc", 64'(done_cyc),  64'(vec[v].exp_done));
      check("vec_done_val", 64'(done_val),  64'(exp_gnt));
      check("vec_gnt_hold", 64'(hold_bad),  64'd0);
      check("vec_peak_cnt", 64'(max_cnt),   64'(vec[v].exp_en));
      tick();
      check("vec_idle_busy", 64'(bus_if.busy), 64'd0);
      check("vec_idle_gnt",  64'(bus_if.gnt),  64'd0);
    end

    // Rotation: all four requesters held, len 2 each.
    do_reset();
    bus_if.req     = 4'b1111;
    bus_if.run_len = {32'd2, 32'd2, 32'd2, 32'd2};
    ng   = 0;
    prev = '0;
    for (int i = 0; i < NREQ; i++) dcnt[i] = 0;
    for (int i = 0; i < 5; i++) begin
      order[i] = -1;
      at[i]    = 0;
    end
    for (int c = 1; c <= 100 && ng < 5; c++) begin
      tick();
      g = bus_if.gnt;
      for (int b = 0; b < NREQ; b++) if (bus_if.done[b]) dcnt[b]++;
      if (g != '0 && prev == '0) begin
        order[ng] = oh2i(g);
        at[ng]    = c;
        $display("txn rot%0d: gnt=%b at cycle %0d", ng, g, c);
        ng++;
      end
      prev = g;
    end
    check("rot_grants", 64'(ng), 64'd5);
    for (int k = 0; k < 5; k++) check("rot_order", 64'(order[k]), 64'(k % NREQ));
    for (int k = 0; k < 4; k++) check("rot_spacing", 64'(at[k+1] - at[k]), 64'd6);
    for (int b = 0; b < NREQ; b++) check("rot_done_once", 64'(dcnt[b]), 64'd1);
    bus_if.req = 4'b0001;
    wait_done(20, dv);
    check("rot_last_done", 64'(dv), 64'b0001);
    bus_if.req = '0;
    tick();

    // Abort: req[3] dropped in RUN at cnt_val=10; run_len and other reqs changed mid-run.
    do_reset();
    bus_if.req     = 4'b1000;
    bus_if.run_len = {32'd20, 32'd0, 32'd0, 32'd2};
    tick();
    check("abort_gnt", 64'(bus_if.gnt), 64'b1000);
    bus_if.run_len = {32'd5, 32'd0, 32'd0, 32'd2};
    bus_if.req     = 4'b1001;
    wait_cnt(32'd10, 40, ok);
    check("abort_reach10", 64'(ok), 64'd1);
    check("abort_gnt_held", 64'(bus_if.gnt), 64'b1000);
    bus_if.req = 4'b0001;
    tick();
    $display("txn abort: abort=%b en=%b gnt=%b done=%b", bus_if.abort, bus_if.cnt_en, bus_if.gnt, bus_if.done);
    check("abort_pulse", 64'(bus_if.abort),  64'b1000);
    check("abort_en",    64'(bus_if.cnt_en), 64'd0);
    check("abort_gntz",  64'(bus_if.gnt),    64'd0);
    check("abort_nodone",64'(bus_if.done),   64'd0);
    tick();
    check("abort_next_gnt", 64'(bus_if.gnt),   64'b0001);
    check("abort_pulse_end",64'(bus_if.abort), 64'd0);
    wait_done(20, dv);
    check("abort_next_done", 64'(dv), 64'b0001);
    bus_if.req = '0;
    tick();

    // Reset while running at cnt_val=40.
    do_reset();
    bus_if.req     = 4'b0100;
    bus_if.run_len = {32'd0, 32'd100, 32'd0, 32'd0};
    wait_cnt(32'd40, 80, ok);
    check("rstrun_reach40", 64'(ok), 64'd1);
    rst = 1'b1;
    tick();
    $display("txn rstrun: gnt=%b en=%b busy=%b", bus_if.gnt, bus_if.cnt_en, bus_if.busy);
    check("rstrun_gnt",   64'(bus_if.gnt),     64'd0);
    check("rstrun_en",    64'(bus_if.cnt_en),  64'd0);
    check("rstrun_clr",   64'(bus_if.cnt_clr), 64'd0);
    check("rstrun_busy",  64'(bus_if.busy),    64'd0);
    check("rstrun_done",  64'(bus_if.done),    64'd0);
    check("rstrun_abort", 64'(bus_if.abort),   64'd0);
    rst = 1'b0;
    bus_if.req     = 4'b1111;
    bus_if.run_len = {32'd1, 32'd1, 32'd1, 32'd1};
    tick();
    check("rstrun_rr_gnt", 64'(bus_if.gnt), 64'b0001);
    bus_if.req = 4'b0001;
    wait_done(20, dv);
    check("rstrun_done_after", 64'(dv), 64'b0001);
    bus_if.req = '0;
    tick();

    check("invariants", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
